// File: rtl/store_queue.sv
// rtl/store_queue.sv - circular store queue with in-order drain to the data cache through an arbiter
module store_queue #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int TAG_WIDTH     = 6,
    parameter int STQ_DEPTH     = 8,
    parameter int STQ_TAG_WIDTH = $clog2(STQ_DEPTH)
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     i_flush,
    input  logic                     i_enq_en,
    input  logic [TAG_WIDTH-1:0]     i_enq_tag,
    input  logic [ADDR_WIDTH-1:0]    i_enq_addr,
    output logic [STQ_TAG_WIDTH-1:0] o_enq_stq_tag,
    output logic                     o_enq_full,
    input  logic                     i_mem_en,
    input  logic [STQ_TAG_WIDTH-1:0] i_mem_stq_tag,
    input  logic [DATA_WIDTH-1:0]    i_mem_data,
    input  logic                     i_retire_en,
    input  logic [TAG_WIDTH-1:0]     i_retire_tag,
    output logic                     o_conflict_en,
    output logic [ADDR_WIDTH-1:0]    o_conflict_addr,
    output logic                     o_arb_req,
    input  logic                     i_arb_gnt,
    output logic                     o_dc_wr_en,
    output logic [ADDR_WIDTH-1:0]    o_dc_addr,
    output logic [DATA_WIDTH-1:0]    o_dc_data
);
    localparam int CW = STQ_TAG_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, REQ, WRITE} state_t;

    logic [STQ_DEPTH-1:0]     valid, data_vld, retired;
    logic [TAG_WIDTH-1:0]     tag_q  [STQ_DEPTH];
    logic [ADDR_WIDTH-1:0]    addr_q [STQ_DEPTH];
    logic [DATA_WIDTH-1:0]    data_q [STQ_DEPTH];
    logic [STQ_TAG_WIDTH-1:0] head, tail;
    logic [CW-1:0]            count;
    state_t                   state, state_next;

    logic [STQ_DEPTH-1:0] retire_hit, retired_eff;
    logic [CW-1:0]        nret;
    logic                 enq_do, mem_ok, free, head_ready;

    assign o_enq_full    = (count == CW'(STQ_DEPTH));
    assign o_enq_stq_tag = tail;
    assign enq_do        = i_enq_en && !o_enq_full && !i_flush;
    assign mem_ok        = i_mem_en && valid[i_mem_stq_tag];
    assign free          = (state == WRITE);
    assign head_ready    = valid[head] && retired[head] && data_vld[head];

    // Same-cycle retire is folded in before the flush decides what survives
    always_comb begin
        retire_hit  = '0;
        retired_eff = '0;
        nret        = '0;
        for (int i = 0; i < STQ_DEPTH; i++) begin
            retire_hit[i]  = i_retire_en && valid[i] && (tag_q[i] == i_retire_tag);
            retired_eff[i] = retired[i] || retire_hit[i];
            nret           = nret + CW'(valid[i] && retired_eff[i]);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            valid    <= '0;
            data_vld <= '0;
            retired  <= '0;
        end else begin
            for (int i = 0; i < STQ_DEPTH; i++) begin
                if (mem_ok && i_mem_stq_tag == STQ_TAG_WIDTH'(i)) data_vld[i] <= 1'b1;
                if (retire_hit[i]) retired[i] <= 1'b1;
                if (i_flush && !retired_eff[i]) valid[i] <= 1'b0;
                if (free && head == STQ_TAG_WIDTH'(i)) valid[i] <= 1'b0;
                if (enq_do && tail == STQ_TAG_WIDTH'(i)) begin
                    valid[i]    <= 1'b1;
                    data_vld[i] <= 1'b0;
                    retired[i]  <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq_do) begin
            tag_q[tail]  <= i_enq_tag;
            addr_q[tail] <= i_enq_addr;
        end
        if (mem_ok) data_q[i_mem_stq_tag] <= i_mem_data;
    end

    // Retired entries are contiguous from head, so a flush rewinds tail to just past them
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (free) head <= head + 1'b1;
            if (i_flush) begin
                tail  <= head + nret[STQ_TAG_WIDTH-1:0];
                count <= nret - CW'(free);
            end else begin
                if (enq_do) tail <= tail + 1'b1;
                count <= count + CW'(enq_do) - CW'(free);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            o_conflict_en   <= 1'b0;
            o_conflict_addr <= '0;
        end else begin
            o_conflict_en   <= mem_ok;
            o_conflict_addr <= mem_ok ? addr_q[i_mem_stq_tag] : '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (head_ready) state_next = REQ;
            REQ:     if (i_arb_gnt)  state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_arb_req  = (state == REQ);
        o_dc_wr_en = (state == WRITE);
        o_dc_addr  = (state == WRITE) ? addr_q[head] : '0;
        o_dc_data  = (state == WRITE) ? data_q[head] : '0;
    end
endmodule

// File: tb/tb_store_queue.sv
// tb/tb_store_queue.sv - directed self-checking bench for store_queue
module tb_store_queue;
    logic        clk = 1'b0;
    logic        n_rst, i_flush, i_enq_en, i_mem_en, i_retire_en, i_arb_gnt;
    logic [5:0]  i_enq_tag, i_retire_tag;
    logic [31:0] i_enq_addr, i_mem_data;
    logic [2:0]  i_mem_stq_tag, o_enq_stq_tag;
    logic        o_enq_full, o_conflict_en, o_arb_req, o_dc_wr_en;
    logic [31:0] o_conflict_addr, o_dc_addr, o_dc_data;
    int          tests = 0;
    int          fails = 0;

    store_queue dut (
        .clk(clk), .n_rst(n_rst), .i_flush(i_flush),
        .i_enq_en(i_enq_en), .i_enq_tag(i_enq_tag), .i_enq_addr(i_enq_addr),
        .o_enq_stq_tag(o_enq_stq_tag), .o_enq_full(o_enq_full),
        .i_mem_en(i_mem_en), .i_mem_stq_tag(i_mem_stq_tag), .i_mem_data(i_mem_data),
        .i_retire_en(i_retire_en), .i_retire_tag(i_retire_tag),
        .o_conflict_en(o_conflict_en), .o_conflict_addr(o_conflict_addr),
        .o_arb_req(o_arb_req), .i_arb_gnt(i_arb_gnt),
        .o_dc_wr_en(o_dc_wr_en), .o_dc_addr(o_dc_addr), .o_dc_data(o_dc_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_flush = 0; i_enq_en = 0; i_enq_tag = 0; i_enq_addr = 0;
        i_mem_en = 0; i_mem_stq_tag = 0; i_mem_data = 0;
        i_retire_en = 0; i_retire_tag = 0; i_arb_gnt = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        n_rst = 0;
        tick(); tick();
        n_rst = 1;
        tick();
    endtask

    task automatic wait_write(input int budget);
        for (int k = 0; k < budget && !o_dc_wr_en; k++) tick();
        tests++;
        if (o_dc_wr_en !== 1'b1) begin
            fails++; $display("FAIL wait_write: o_dc_wr_en got %0b expected 1 within %0d cycles", o_dc_wr_en, budget);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        n_rst = 0;
        #1;
        tests++;
        if ({o_enq_stq_tag, o_enq_full, o_conflict_en, o_conflict_addr, o_arb_req, o_dc_wr_en, o_dc_addr, o_dc_data} !== '0) begin
            fails++; $display("FAIL reset_outputs: got nonzero outputs expected all 0");
        end
        tick();
        tests++;
        if (dut.count !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", dut.count); end
        n_rst = 1;
        tick();
    endtask

    task automatic test_enqueue();
        for (int i = 0; i < 3; i++) begin
            i_enq_en = 1; i_enq_tag = 6'(5 + i); i_enq_addr = 32'h100 + 32'(4 * i);
            #1;
            tests++;
            if (o_enq_stq_tag !== 3'(i) || o_enq_full !== 1'b0) begin
                fails++; $display("FAIL enq_tag%0d: got tag %0d full %0b expected tag %0d full 0", i, o_enq_stq_tag, o_enq_full, i);
            end
            tick();
        end
        i_enq_en = 0;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (o_arb_req !== 1'b0 || o_dc_wr_en !== 1'b0) begin
                fails++; $display("FAIL enq_no_drain: got req %0b wr %0b expected 0 0", o_arb_req, o_dc_wr_en);
            end
            tick();
        end
        tests++;
        if (dut.count !== 4'd3) begin fails++; $display("FAIL enq_count: got %0d expected 3", dut.count); end
    endtask

    task automatic test_mem_write();
        i_mem_en = 1; i_mem_stq_tag = 1; i_mem_data = 32'hDEADBEEF;
        tick();
        i_mem_en = 0;
        tests++;
        if (o_conflict_en !== 1'b1 || o_conflict_addr !== 32'h104) begin
            fails++; $display("FAIL conflict_pulse: got en %0b addr %0h expected 1 104", o_conflict_en, o_conflict_addr);
        end
        tick();
        tests++;
        if (o_conflict_en !== 1'b0) begin fails++; $display("FAIL conflict_one_cycle: got %0b expected 0", o_conflict_en); end
        i_mem_en = 1; i_mem_stq_tag = 6; i_mem_data = 32'h12345678;
        tick();
        i_mem_en = 0;
        tests++;
        if (o_conflict_en !== 1'b0) begin fails++; $display("FAIL conflict_invalid: got %0b expected 0", o_conflict_en); end
    endtask

    task automatic test_drain();
        i_mem_en = 1; i_mem_stq_tag = 0; i_mem_data = 32'hA5A5A5A5;
        tick();
        i_mem_en = 0;
        tests++;
        if (o_conflict_addr !== 32'h100) begin fails++; $display("FAIL conflict_e0: got %0h expected 100", o_conflict_addr); end
        i_retire_en = 1; i_retire_tag = 5; i_arb_gnt = 0;
        tick();
        i_retire_en = 0;
        tick();
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (o_arb_req !== 1'b1 || o_dc_wr_en !== 1'b0) begin
                fails++; $display("FAIL req_hold%0d: got req %0b wr %0b expected 1 0", i, o_arb_req, o_dc_wr_en);
            end
            tick();
        end
        i_arb_gnt = 1;
        tests++;
        if (o_arb_req !== 1'b1) begin fails++; $display("FAIL req_at_gnt: got %0b expected 1", o_arb_req); end
        tick();
        i_arb_gnt = 0;
        tests++;
        if (o_dc_wr_en !== 1'b1 || o_dc_addr !== 32'h100 || o_dc_data !== 32'hA5A5A5A5 || o_arb_req !== 1'b0) begin
            fails++; $display("FAIL dc_write: got wr %0b addr %0h data %0h req %0b expected 1 100 a5a5a5a5 0", o_dc_wr_en, o_dc_addr, o_dc_data, o_arb_req);
        end
        tick();
        tests++;
        if (dut.count !== 4'd2 || o_dc_wr_en !== 1'b0) begin
            fails++; $display("FAIL drain_count: got count %0d wr %0b expected 2 0", dut.count, o_dc_wr_en);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            i_enq_en = 1; i_enq_tag = 6'(10 + i); i_enq_addr = 32'h200 + 32'(4 * i);
            #1;
            tests++;
            if (o_enq_stq_tag !== 3'(i)) begin fails++; $display("FAIL full_tag%0d: got %0d expected %0d", i, o_enq_stq_tag, i); end
            tick();
        end
        i_enq_en = 0;
        tests++;
        if (o_enq_full !== 1'b1) begin fails++; $display("FAIL full_set: got %0b expected 1", o_enq_full); end
        i_enq_en = 1; i_enq_tag = 6'd30; i_enq_addr = 32'h999;
        tick();
        i_enq_en = 0;
        tests++;
        if (dut.tail !== 3'd0 || dut.count !== 4'd8) begin
            fails++; $display("FAIL full_drop: got tail %0d count %0d expected 0 8", dut.tail, dut.count);
        end
        i_mem_en = 1; i_mem_stq_tag = 0; i_mem_data = 32'h0BADF00D;
        i_retire_en = 1; i_retire_tag = 6'd10; i_arb_gnt = 1;
        tick();
        i_mem_en = 0; i_retire_en = 0;
        wait_write(10);
        tests++;
        if (o_dc_addr !== 32'h200 || o_dc_data !== 32'h0BADF00D) begin
            fails++; $display("FAIL full_drain: got addr %0h data %0h expected 200 badf00d", o_dc_addr, o_dc_data);
        end
        i_enq_en = 1;
        tick();
        i_enq_en = 0;
        tests++;
        if (dut.count !== 4'd7 || dut.tail !== 3'd0 || o_enq_full !== 1'b0) begin
            fails++; $display("FAIL full_free_drop: got count %0d tail %0d full %0b expected 7 0 0", dut.count, dut.tail, o_enq_full);
        end
        i_enq_en = 1;
        #1;
        tests++;
        if (o_enq_stq_tag !== 3'd0) begin fails++; $display("FAIL wrap_tag: got %0d expected 0", o_enq_stq_tag); end
        tick();
        i_enq_en = 0; i_arb_gnt = 0;
        tests++;
        if (o_enq_full !== 1'b1 || dut.tail !== 3'd1) begin
            fails++; $display("FAIL wrap_full: got full %0b tail %0d expected 1 1", o_enq_full, dut.tail);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            i_enq_en = 1; i_enq_tag = 6'(1 + i); i_enq_addr = 32'h300 + 32'(4 * i);
            tick();
        end
        i_enq_en = 0;
        for (int i = 0; i < 4; i++) begin
            i_mem_en = 1; i_mem_stq_tag = 3'(i); i_mem_data = 32'h1000 + 32'(i);
            tick();
        end
        i_mem_en = 0;
        i_retire_en = 1; i_retire_tag = 1;
        tick();
        i_retire_tag = 2; i_flush = 1; i_enq_en = 1; i_enq_tag = 9; i_enq_addr = 32'h999;
        tick();
        clear_inputs();
        tests++;
        if (dut.count !== 4'd2 || dut.tail !== 3'd2 || dut.head !== 3'd0) begin
            fails++; $display("FAIL flush_state: got count %0d tail %0d head %0d expected 2 2 0", dut.count, dut.tail, dut.head);
        end
        i_retire_en = 1; i_retire_tag = 3;
        tick();
        i_retire_en = 0; i_arb_gnt = 1;
        wait_write(10);
        tests++;
        if (o_dc_addr !== 32'h300 || o_dc_data !== 32'h1000) begin
            fails++; $display("FAIL flush_drain1: got addr %0h data %0h expected 300 1000", o_dc_addr, o_dc_data);
        end
        tick();
        wait_write(10);
        tests++;
        if (o_dc_addr !== 32'h304 || o_dc_data !== 32'h1001) begin
            fails++; $display("FAIL flush_drain2: got addr %0h data %0h expected 304 1001", o_dc_addr, o_dc_data);
        end
        tick();
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (o_dc_wr_en !== 1'b0 || o_arb_req !== 1'b0) begin
                fails++; $display("FAIL flush_no_tag3: got wr %0b req %0b expected 0 0", o_dc_wr_en, o_arb_req);
            end
            tick();
        end
        tests++;
        if (dut.count !== 4'd0) begin fails++; $display("FAIL flush_empty: got %0d expected 0", dut.count); end
        i_arb_gnt = 0;
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        i_enq_en = 1; i_enq_tag = 20; i_enq_addr = 32'h400;
        tick();
        i_enq_en = 0;
        i_mem_en = 1; i_mem_stq_tag = 0; i_mem_data = 32'h55;
        i_retire_en = 1; i_retire_tag = 20; i_arb_gnt = 1;
        tick();
        i_mem_en = 0; i_retire_en = 0;
        wait_write(10);
        n_rst = 0;
        #1;
        tests++;
        if (o_dc_wr_en !== 1'b0 || o_arb_req !== 1'b0 || o_dc_addr !== 32'h0 || o_dc_data !== 32'h0) begin
            fails++; $display("FAIL rst_mid_write: got wr %0b req %0b addr %0h data %0h expected 0 0 0 0", o_dc_wr_en, o_arb_req, o_dc_addr, o_dc_data);
        end
        tests++;
        if (o_enq_full !== 1'b0 || o_enq_stq_tag !== 3'd0 || o_conflict_en !== 1'b0 || o_conflict_addr !== 32'h0 || dut.count !== 4'd0) begin
            fails++; $display("FAIL rst_mid_state: got full %0b tag %0d conf %0b caddr %0h count %0d expected all 0", o_enq_full, o_enq_stq_tag, o_conflict_en, o_conflict_addr, dut.count);
        end
        clear_inputs();
        tick();
        n_rst = 1;
        tick();
    endtask

    initial begin
        clear_inputs();
        n_rst = 0;
        test_reset();
        test_enqueue();
        test_mem_write();
        test_drain();
        test_full();
        test_flush();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
